// File: rtl/decoder_scan_pkg.sv
// Shared types, constants and channel-search helper for the decoder scan controller.
package decoder_scan_pkg;

  localparam int unsigned NCH   = 8;
  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    BLANK
  } state_t;

  // First set mask bit strictly after cur, searching cyclically 7->0.
  // Returns cur when the mask is empty.
  function automatic logic [SEL_W-1:0] next_chan(input logic [NCH-1:0]   mask,
                                                 input logic [SEL_W-1:0] cur);
    logic [SEL_W-1:0] res;
    logic [SEL_W-1:0] idx;
    logic             found;
    res   = cur;
    found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = SEL_W'(32'(cur) + i);
      if (!found && mask[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder_scan_pick.sv
// Combinational channel picker: lowest eligible channel for scan entry and
// next eligible channel after the current one for dwell terminal.
module decoder_scan_pick
  import decoder_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] lowest,
  output logic [SEL_W-1:0] next,
  output logic             any
);

  // Searching "after the top channel" wraps to 0 and yields the lowest set bit.
  always_comb begin
    any    = |mask;
    lowest = next_chan(mask, SEL_W'(NCH - 1));
    next   = next_chan(mask, cur);
  end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan select generator driving a 3-to-8 decoder's a/b/c inputs.
// Optional build macro: DECODER_SCAN_BLANK_EN inserts a one-cycle blank
// between channels.
module decoder_scan_ctrl
  import decoder_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         chan_mask,
  output logic [2:0]         sel,
  output logic               sel_vld,
  output logic               step,
  output logic               wrap
);

  state_t             state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [SEL_W-1:0]   sel_n;
  logic               vld_n, step_n, wrap_n;
  logic [SEL_W-1:0]   pick_lowest, pick_next;
  logic               pick_any;
  logic               term;
`ifdef DECODER_SCAN_BLANK_EN
  logic               wrap_pend, wrap_pend_n;
`endif

  decoder_scan_pick u_pick (
    .mask   (chan_mask),
    .cur    (sel),
    .lowest (pick_lowest),
    .next   (pick_next),
    .any    (pick_any)
  );

  // Terminal uses the live dwell value, so a shrinking dwell below cnt
  // lets the counter run around through its maximum.
  assign term = (cnt == dwell);

  // Next-state and next-output decode; all outputs are registered below.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    vld_n   = sel_vld;
    step_n  = 1'b0;
    wrap_n  = 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
    wrap_pend_n = wrap_pend;
`endif
    case (state)
      IDLE: begin
        vld_n = 1'b0;
        cnt_n = '0;
        if (en && pick_any) begin
          state_n = RUN;
          sel_n   = pick_lowest;
          vld_n   = 1'b1;
          step_n  = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_n = IDLE;
          vld_n   = 1'b0;
          cnt_n   = '0;
        end else if (term) begin
          cnt_n = '0;
          if (!pick_any) begin
            state_n = IDLE;
            vld_n   = 1'b0;
          end else begin
            sel_n = pick_next;
`ifdef DECODER_SCAN_BLANK_EN
            state_n     = BLANK;
            vld_n       = 1'b0;
            wrap_pend_n = (pick_next <= sel);
`else
            step_n = 1'b1;
            wrap_n = (pick_next <= sel);
`endif
          end
        end else begin
          cnt_n = cnt + DWELL_W'(1);
        end
      end
`ifdef DECODER_SCAN_BLANK_EN
      BLANK: begin
        if (!en) begin
          state_n = IDLE;
          vld_n   = 1'b0;
        end else begin
          state_n = RUN;
          vld_n   = 1'b1;
          step_n  = 1'b1;
          wrap_n  = wrap_pend;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        vld_n   = 1'b0;
        cnt_n   = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      sel_vld <= 1'b0;
      step    <= 1'b0;
      wrap    <= 1'b0;
`ifdef DECODER_SCAN_BLANK_EN
      wrap_pend <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sel     <= sel_n;
      sel_vld <= vld_n;
      step    <= step_n;
      wrap    <= wrap_n;
`ifdef DECODER_SCAN_BLANK_EN
      wrap_pend <= wrap_pend_n;
`endif
    end
  end

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Table-driven bench for decoder_scan_ctrl plus hand sequences for
// asynchronous reset and counter run-around.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] dwell;
  logic [7:0] chan_mask;
  logic [2:0] sel;
  logic       sel_vld, step, wrap;

  int checks = 0;
  int errors = 0;

`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLANK_X = 1;
`else
  localparam int BLANK_X = 0;
`endif

  typedef struct {
    logic       rst_before;
    logic       en;
    logic [7:0] dwell;
    logic [7:0] mask;
    logic [2:0] sel;
    logic       vld;
    logic       step;
    logic       wrap;
  } vec_t;

  vec_t vq[$];

  decoder_scan_ctrl #(.DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dwell     (dwell),
    .chan_mask (chan_mask),
    .sel       (sel),
    .sel_vld   (sel_vld),
    .step      (step),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic [7:0] d, input logic [7:0] m,
                     input logic [2:0] s, input logic v, input logic st, input logic w);
    vec_t x;
    x.rst_before = r; x.en = e; x.dwell = d; x.mask = m;
    x.sel = s; x.vld = v; x.step = st; x.wrap = w;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] s, input logic v,
                          input logic st, input logic w);
    chk({tag, " sel"},  int'(sel),     int'(s));
    chk({tag, " vld"},  int'(sel_vld), int'(v));
    chk({tag, " step"}, int'(step),    int'(st));
    chk({tag, " wrap"}, int'(wrap),    int'(w));
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    chk_outs({tag, " rst"}, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; dwell = '0; chan_mask = '0;

`ifndef DECODER_SCAN_BLANK_EN
    // Full mask, dwell 2: each channel 3 cycles, wrap on return to 0.
    for (int k = 0; k <= 8; k++)
      for (int h = 0; h < 3; h++)
        add((k == 0 && h == 0), 1'b1, 8'd2, 8'hFF, 3'(k % 8), 1'b1, (h == 0), (h == 0 && k == 8));
    // Sparse mask, dwell 0: 2,5,7,2,5 with step every cycle.
    add(1, 1, 8'd0, 8'hA4, 3'd2, 1, 1, 0);
    add(0, 1, 8'd0, 8'hA4, 3'd5, 1, 1, 0);
    add(0, 1, 8'd0, 8'hA4, 3'd7, 1, 1, 0);
    add(0, 1, 8'd0, 8'hA4, 3'd2, 1, 1, 1);
    add(0, 1, 8'd0, 8'hA4, 3'd5, 1, 1, 0);
    // Single channel, dwell 3: step every 4th cycle, wrap after the first.
    for (int e = 0; e < 9; e++)
      add((e == 0), 1'b1, 8'd3, 8'h01, 3'd0, 1'b1, (e % 4 == 0), (e % 4 == 0 && e > 0));
    // Mask cleared mid-dwell on channel 3, then restored to 8'h30.
    for (int e = 0; e < 20; e++)
      add((e == 0), 1'b1, 8'd5, 8'hFF, 3'(e / 6), 1'b1, (e % 6 == 0), 1'b0);
    for (int e = 0; e < 4; e++)
      add(0, 1, 8'd5, 8'h00, 3'd3, 1, 0, 0);
    add(0, 1, 8'd5, 8'h00, 3'd3, 0, 0, 0);
    add(0, 1, 8'd5, 8'h00, 3'd3, 0, 0, 0);
    add(0, 1, 8'd5, 8'h30, 3'd4, 1, 1, 0);
    // en dropped on a terminal cycle, restart at lowest, live dwell change.
    add(1, 1, 8'd1, 8'hFF, 3'd0, 1, 1, 0);
    add(0, 1, 8'd1, 8'hFF, 3'd0, 1, 0, 0);
    add(0, 1, 8'd1, 8'hFF, 3'd1, 1, 1, 0);
    add(0, 1, 8'd1, 8'hFF, 3'd1, 1, 0, 0);
    add(0, 0, 8'd1, 8'hFF, 3'd1, 0, 0, 0);
    add(0, 0, 8'd1, 8'hFF, 3'd1, 0, 0, 0);
    add(0, 1, 8'd1, 8'h0C, 3'd2, 1, 1, 0);
    add(0, 1, 8'd0, 8'h0C, 3'd3, 1, 1, 0);
    add(0, 1, 8'd0, 8'h0C, 3'd2, 1, 1, 1);
    // en with empty mask stays idle; top channel alone on entry.
    add(1, 1, 8'd0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 1, 8'd0, 8'h00, 3'd0, 0, 0, 0);
    add(0, 1, 8'd0, 8'h80, 3'd7, 1, 1, 0);
    add(0, 1, 8'd0, 8'h80, 3'd7, 1, 1, 1);
`else
    // Blank mode, mask 8'h03, dwell 1: two valid cycles then one blank.
    add(1, 1, 8'd1, 8'h03, 3'd0, 1, 1, 0);
    add(0, 1, 8'd1, 8'h03, 3'd0, 1, 0, 0);
    add(0, 1, 8'd1, 8'h03, 3'd1, 0, 0, 0);
    add(0, 1, 8'd1, 8'h03, 3'd1, 1, 1, 0);
    add(0, 1, 8'd1, 8'h03, 3'd1, 1, 0, 0);
    add(0, 1, 8'd1, 8'h03, 3'd0, 0, 0, 0);
    add(0, 1, 8'd1, 8'h03, 3'd0, 1, 1, 1);
    add(0, 1, 8'd1, 8'h03, 3'd0, 1, 0, 0);
    add(0, 1, 8'd1, 8'h00, 3'd0, 0, 0, 0);
`endif

    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (vq[i]) begin
      if (vq[i].rst_before) pulse_reset($sformatf("vec%0d", i));
      en = vq[i].en; dwell = vq[i].dwell; chan_mask = vq[i].mask;
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vq[i].sel, vq[i].vld, vq[i].step, vq[i].wrap);
    end

    // Asynchronous reset mid-dwell clears outputs before the next edge.
    pulse_reset("async");
    en = 1'b1; dwell = 8'd5; chan_mask = 8'hFF;
    repeat (8 + BLANK_X) @(posedge clk);
    #1;
    chk_outs("pre_async", 3'd1, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_outs("async_mid", 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("async_restart", 3'd0, 1'b1, 1'b1, 1'b0);

    // Dwell shrunk below cnt: counter runs through 255 and back to 2.
    pulse_reset("runaround");
    en = 1'b1; dwell = 8'd5; chan_mask = 8'h03;
    repeat (5) @(posedge clk);
    #1;
    chk_outs("runaround_pre", 3'd0, 1'b1, 1'b0, 1'b0);
    dwell = 8'd2;
    n = 0;
    while (!step && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("runaround_cycles", n, 255 + BLANK_X);
    chk("runaround_sel", int'(sel), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
